axi4_slave_mem: RTL and testbench

AXI4_SLAVE_MEM -- requirements
Module: axi4_slave_mem

---
 rtl/axi4_slave_mem.sv | 249 ++++++++++++++++++++++++
 tb/tb_axi4_slave_mem.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_slave_mem.sv
// axi4_slave_mem: AXI4 slave backed by a register-array memory.
// All bursts are INCR with full-width beats; independent read and write engines.
// Optional build macro AXI4_SLAVE_MEM_RANGE_CHK_EN: bursts whose start address has
// bits set above the memory range get SLVERR, suppressed writes and zero read data.
//
// Write FSM
//   state  | meaning
//   W_IDLE | awready high, waiting for an AW handshake
//   W_DATA | wready high, accepting awlen+1 beats
//   W_DLY  | response delay down-counter running
//   W_RESP | bvalid raised on entry+1, held until bready
// Read FSM
//   state  | meaning
//   R_IDLE | arready high, waiting for an AR handshake
//   R_DLY  | response delay down-counter running
//   R_DATA | rvalid high, streaming arlen+1 beats

module axi4_slave_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_AW     = 8,
    parameter int RESP_DLY   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [31:0]             awaddr,
    input  logic [7:0]              awlen,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [31:0]             araddr,
    input  logic [7:0]              arlen,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int STRB_W  = DATA_WIDTH / 8;
    localparam int B       = $clog2(STRB_W);
    localparam int ADDR_HI = MEM_AW + B;
    localparam logic [3:0] R_DLY_LOAD = 4'(RESP_DLY);
    // W_RESP spends one cycle raising bvalid, so the write counter starts one lower
    localparam logic [3:0] W_DLY_LOAD = (RESP_DLY > 0) ? 4'(RESP_DLY - 1) : 4'd0;
    localparam logic [MEM_AW-1:0] ADDR_ONE = 1;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_DLY, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_DLY, R_DATA} r_state_t;

    logic [DATA_WIDTH-1:0] mem [0:(1<<MEM_AW)-1];

    w_state_t          w_state;
    logic [MEM_AW-1:0] w_addr;
    logic [7:0]        w_len;
    logic [7:0]        w_beat;
    logic              w_err;
    logic              w_oor;
    logic [3:0]        w_cnt;
    logic              wr_en;

    r_state_t          r_state;
    logic [MEM_AW-1:0] r_addr;
    logic [MEM_AW-1:0] r_next;
    logic [7:0]        r_len;
    logic [7:0]        r_beat;
    logic              r_oor;
    logic [3:0]        r_cnt;

    logic aw_hi_nz;
    logic ar_hi_nz;
    logic aw_oor;
    logic ar_oor;
    logic unused_addr_bits;

    assign aw_hi_nz = |(awaddr >> ADDR_HI);
    assign ar_hi_nz = |(araddr >> ADDR_HI);

`ifdef AXI4_SLAVE_MEM_RANGE_CHK_EN
    assign aw_oor = aw_hi_nz;
    assign ar_oor = ar_hi_nz;
    assign unused_addr_bits = ^{awaddr[B-1:0], araddr[B-1:0]};
`else
    assign aw_oor = 1'b0;
    assign ar_oor = 1'b0;
    assign unused_addr_bits = ^{awaddr[B-1:0], araddr[B-1:0], aw_hi_nz, ar_hi_nz};
`endif

    assign wr_en  = (w_state == W_DATA) && wready && wvalid && !w_oor;
    assign r_next = r_addr + ADDR_ONE;

    // Write engine: AW capture, beat acceptance, delayed B response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= 2'b00;
            bid     <= '0;
            w_addr  <= '0;
            w_len   <= 8'd0;
            w_beat  <= 8'd0;
            w_err   <= 1'b0;
            w_oor   <= 1'b0;
            w_cnt   <= 4'd0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (awready && awvalid) begin
                        awready <= 1'b0;
                        wready  <= 1'b1;
                        bid     <= awid;
                        w_addr  <= awaddr[ADDR_HI-1:B];
                        w_len   <= awlen;
                        w_beat  <= 8'd0;
                        w_err   <= 1'b0;
                        w_oor   <= aw_oor;
                        w_state <= W_DATA;
                    end else begin
                        awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (wvalid) begin
                        w_addr <= w_addr + ADDR_ONE;
                        w_beat <= w_beat + 8'd1;
                        if (w_beat == w_len) begin
                            wready <= 1'b0;
                            bresp  <= (w_oor || w_err || !wlast) ? 2'b10 : 2'b00;
                            if (RESP_DLY == 0) begin
                                w_state <= W_RESP;
                            end else begin
                                w_cnt   <= W_DLY_LOAD;
                                w_state <= W_DLY;
                            end
                        end else if (wlast) begin
                            w_err <= 1'b1;
                        end
                    end
                end
                W_DLY: begin
                    if (w_cnt == 4'd0) begin
                        w_state <= W_RESP;
                    end else begin
                        w_cnt <= w_cnt - 4'd1;
                    end
                end
                W_RESP: begin
                    if (!bvalid) begin
                        bvalid <= 1'b1;
                    end else if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Byte-lane memory writes; array is intentionally left unreset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrb[i]) begin
                    mem[w_addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    // Read engine: AR capture, delay, registered beat fetch (sees pre-write data)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rresp   <= 2'b00;
            rid     <= '0;
            rdata   <= '0;
            r_addr  <= '0;
            r_len   <= 8'd0;
            r_beat  <= 8'd0;
            r_oor   <= 1'b0;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (arready && arvalid) begin
                        arready <= 1'b0;
                        rid     <= arid;
                        r_addr  <= araddr[ADDR_HI-1:B];
                        r_len   <= arlen;
                        r_beat  <= 8'd0;
                        r_oor   <= ar_oor;
                        r_cnt   <= R_DLY_LOAD;
                        r_state <= R_DLY;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                R_DLY: begin
                    if (r_cnt == 4'd0) begin
                        rvalid  <= 1'b1;
                        rdata   <= r_oor ? '0 : mem[r_addr];
                        rresp   <= r_oor ? 2'b10 : 2'b00;
                        rlast   <= (r_len == 8'd0);
                        r_state <= R_DATA;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        if (rlast) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            arready <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            r_addr <= r_next;
                            r_beat <= r_beat + 8'd1;
                            rdata  <= r_oor ? '0 : mem[r_next];
                            rlast  <= ((r_beat + 8'd1) == r_len);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_slave_mem.sv
// tb_axi4_slave_mem: directed checks of axi4_slave_mem (DATA_WIDTH=32, MEM_AW=8, RESP_DLY=2).

module tb_axi4_slave_mem;

    logic        clk;
    logic        rst_n;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

`ifdef AXI4_SLAVE_MEM_RANGE_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] wbuf [16];
    logic [3:0]  sbuf [16];
    logic        lbuf [16];
    logic [31:0] rbuf [16];

    axi4_slave_mem #(
        .DATA_WIDTH(32),
        .ID_WIDTH  (4),
        .MEM_AW    (8),
        .RESP_DLY  (2)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .awid   (awid),
        .awaddr (awaddr),
        .awlen  (awlen),
        .awvalid(awvalid),
        .awready(awready),
        .wdata  (wdata),
        .wstrb  (wstrb),
        .wlast  (wlast),
        .wvalid (wvalid),
        .wready (wready),
        .bid    (bid),
        .bresp  (bresp),
        .bvalid (bvalid),
        .bready (bready),
        .arid   (arid),
        .araddr (araddr),
        .arlen  (arlen),
        .arvalid(arvalid),
        .arready(arready),
        .rid    (rid),
        .rdata  (rdata),
        .rresp  (rresp),
        .rlast  (rlast),
        .rvalid (rvalid),
        .rready (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Burst write of wbuf/sbuf/lbuf[0..len]; bready held off for bready_dly cycles
    task automatic wr_burst(input string tag, input logic [3:0] id, input logic [31:0] addr,
                            input int len, input logic [1:0] exp_resp, input int bready_dly);
        int k;
        awid = id; awaddr = addr; awlen = 8'(len); awvalid = 1'b1;
        k = 0;
        while (!awready && k < 50) begin tick(); k++; end
        chk({tag, "_aw_to"}, 32'(k < 50), 32'd1);
        tick();
        awvalid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            wdata = wbuf[b]; wstrb = sbuf[b]; wlast = lbuf[b]; wvalid = 1'b1;
            k = 0;
            while (!wready && k < 50) begin tick(); k++; end
            chk({tag, "_w_to"}, 32'(k < 50), 32'd1);
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0;
        k = 0;
        while (!bvalid && k < 20) begin tick(); k++; end
        chk({tag, "_b_lat"}, 32'(k), 32'd3);
        for (int d = 0; d < bready_dly; d++) begin
            tick();
            chk({tag, "_b_hold"}, 32'(bvalid), 32'd1);
        end
        chk({tag, "_bid"}, 32'(bid), 32'(id));
        chk({tag, "_bresp"}, 32'(bresp), 32'(exp_resp));
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk({tag, "_b_drop"}, 32'(bvalid), 32'd0);
    endtask

    // Burst read checked against rbuf[0..len]; rready dropped for 3 cycles at stall_beat
    task automatic rd_burst(input string tag, input logic [3:0] id, input logic [31:0] addr,
                            input int len, input logic [1:0] exp_resp, input int stall_beat);
        int k;
        arid = id; araddr = addr; arlen = 8'(len); arvalid = 1'b1;
        k = 0;
        while (!arready && k < 50) begin tick(); k++; end
        chk({tag, "_ar_to"}, 32'(k < 50), 32'd1);
        tick();
        arvalid = 1'b0;
        rready = 1'b1;
        k = 0;
        while (!rvalid && k < 20) begin tick(); k++; end
        chk({tag, "_r_lat"}, 32'(k), 32'd3);
        for (int b = 0; b <= len; b++) begin
            if (b == stall_beat) begin
                rready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    chk({tag, "_hold_valid"}, 32'(rvalid), 32'd1);
                    chk({tag, "_hold_data"}, rdata, rbuf[b]);
                    chk({tag, "_hold_last"}, 32'(rlast), 32'(b == len));
                end
                rready = 1'b1;
            end
            chk({tag, "_rvalid"}, 32'(rvalid), 32'd1);
            chk({tag, "_rdata"}, rdata, rbuf[b]);
            chk({tag, "_rresp"}, 32'(rresp), 32'(exp_resp));
            chk({tag, "_rlast"}, 32'(rlast), 32'(b == len));
            chk({tag, "_rid"}, 32'(rid), 32'(id));
            tick();
        end
        rready = 1'b0;
        chk({tag, "_r_drop"}, 32'(rvalid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;

        // reset state
        #12;
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_wready", 32'(wready), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rlast", 32'(rlast), 32'd0);
        chk("rst_bresp", 32'(bresp), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rel_awready", 32'(awready), 32'd1);
        chk("rel_arready", 32'(arready), 32'd1);

        // 5-beat burst at an aliased address
        for (int i = 0; i < 5; i++) begin
            wbuf[i] = 32'(i); sbuf[i] = 4'hF; lbuf[i] = (i == 4);
            rbuf[i] = CHK ? 32'd0 : 32'(i);
        end
        wr_burst("b5", 4'd3, 32'hC000_0000, 4, CHK ? 2'b10 : 2'b00, 0);
        rd_burst("b5", 4'd6, 32'hC000_0000, 4, CHK ? 2'b10 : 2'b00, 99);

        // byte-strobe merge
        wbuf[0] = 32'hCAFE_CAFE; sbuf[0] = 4'hF; lbuf[0] = 1'b1;
        wr_burst("strb_a", 4'd1, 32'h0000_0010, 0, 2'b00, 0);
        wbuf[0] = 32'h0000_1234; sbuf[0] = 4'b0011; lbuf[0] = 1'b1;
        wr_burst("strb_b", 4'd2, 32'h0000_0010, 0, 2'b00, 1);
        rbuf[0] = 32'hCAFE_1234;
        rd_burst("strb", 4'd4, 32'h0000_0010, 0, 2'b00, 99);

        // early wlast: beats still follow awlen, SLVERR; read with rready stall
        for (int i = 0; i < 4; i++) begin
            wbuf[i] = 32'hA0 + 32'(i); sbuf[i] = 4'hF; lbuf[i] = (i == 1);
            rbuf[i] = 32'hA0 + 32'(i);
        end
        wr_burst("wlast", 4'd5, 32'h0000_0040, 3, 2'b10, 2);
        rd_burst("stall", 4'd9, 32'h0000_0040, 3, 2'b00, 2);

        // wrap past the top word at an aliased address
        wbuf[0] = 32'h1111_1111; wbuf[1] = 32'h2222_2222;
        sbuf[0] = 4'hF; sbuf[1] = 4'hF; lbuf[0] = 1'b0; lbuf[1] = 1'b1;
        wr_burst("wrap_hi", 4'd7, 32'hC000_03FC, 1, CHK ? 2'b10 : 2'b00, 0);
        rbuf[0] = CHK ? 32'd0 : 32'h2222_2222;
        rd_burst("alias", 4'd8, 32'hC000_0400, 0, CHK ? 2'b10 : 2'b00, 99);

        // wrap in range: beat 2 of a burst at 0x3FC lands in word 0
        wbuf[0] = 32'h3333_3333; wbuf[1] = 32'h4444_4444;
        wr_burst("wrap_lo", 4'd10, 32'h0000_03FC, 1, 2'b00, 0);
        rbuf[0] = 32'h4444_4444;
        rd_burst("wrap_w0", 4'd11, 32'h0000_0000, 0, 2'b00, 99);
        rbuf[0] = 32'h3333_3333; rbuf[1] = 32'h4444_4444;
        rd_burst("wrap_rd", 4'd12, 32'h0000_03FC, 1, 2'b00, 99);

        // mid-burst reset aborts with no response
        awid = 4'd13; awaddr = 32'h0000_0080; awlen = 8'd3; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        wdata = 32'hDEAD_0000; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        wvalid = 1'b0;
        #2;
        chk("mid_rst_wready", 32'(wready), 32'd0);
        chk("mid_rst_awready", 32'(awready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("mid_rel_awready", 32'(awready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("mid_no_bvalid", 32'(bvalid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
